// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C command sequencer: field widths, FSM encoding
// and the packed command layout {rw, addr, data}.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;
    localparam int CMD_W      = 1 + I2C_ADDR_W + I2C_DATA_W;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] BUSY  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_ISSUE = ISSUE,
        ST_BUSY  = BUSY,
        ST_DONE  = DONE
    } seq_state_t;

    typedef struct packed {
        logic                  rw;
        logic [I2C_ADDR_W-1:0] addr;
        logic [I2C_DATA_W-1:0] data;
    } i2c_cmd_t;

    function automatic logic [CMD_W-1:0] pack_cmd(input logic                  rw,
                                                  input logic [I2C_ADDR_W-1:0] addr,
                                                  input logic [I2C_DATA_W-1:0] data);
        return {rw, addr, data};
    endfunction

endpackage

// File: rtl/i2c_cmd_fifo.sv
// Synchronous command FIFO with one extra pointer bit to tell full from empty.
// A pop frees the head slot in the same cycle, so a push alongside it is accepted even when full.
module i2c_cmd_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Feeds buffered host transactions to I2C_Master one at a time over its enable/ready
// handshake, reports completions on the response port and flags commands never accepted.
module i2c_cmd_sequencer
    import i2c_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ACC_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic                  cmd_rw,
    input  logic [I2C_ADDR_W-1:0] cmd_addr,
    input  logic [I2C_DATA_W-1:0] cmd_data,
    output logic                  cmd_ready,
    output logic [I2C_ADDR_W-1:0] m_addr,
    output logic [I2C_DATA_W-1:0] m_data_in,
    output logic                  m_rw,
    output logic                  m_enable,
    input  logic                  m_ready,
    input  logic [I2C_DATA_W-1:0] m_data_out,
    output logic                  rsp_valid,
    output logic                  rsp_rw,
    output logic [I2C_DATA_W-1:0] rsp_data,
    output logic                  err_timeout,
    output logic                  busy
);

    localparam int              CNT_W  = $clog2(ACC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(ACC_TIMEOUT - 1);

    seq_state_t       state;
    seq_state_t       state_nxt;
    logic [CNT_W-1:0] to_cnt;
    logic             timeout_hit;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CMD_W-1:0] fifo_dout;
    i2c_cmd_t         head;
    logic             push;
    logic             pop;

    assign head      = i2c_cmd_t'(fifo_dout);
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == ST_IDLE) && !fifo_empty && m_ready;
    assign m_enable  = (state == ST_ISSUE);
    assign rsp_valid = (state == ST_DONE);
    assign busy      = !fifo_empty || (state != ST_IDLE);

    i2c_cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (pack_cmd(cmd_rw, cmd_addr, cmd_data)),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A master that drops ready wins over a timeout landing in the same cycle.
    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE:  if (pop) state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                if (!m_ready) begin
                    state_nxt = ST_BUSY;
                end else if (to_cnt == TO_MAX) begin
                    state_nxt   = ST_IDLE;
                    timeout_hit = 1'b1;
                end
            end
            ST_BUSY:  if (m_ready) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            to_cnt      <= '0;
            m_addr      <= '0;
            m_data_in   <= '0;
            m_rw        <= 1'b0;
            rsp_rw      <= 1'b0;
            rsp_data    <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            err_timeout <= timeout_hit;
            if (pop) begin
                m_rw      <= head.rw;
                m_addr    <= head.addr;
                m_data_in <= head.data;
                to_cnt    <= '0;
            end else if (state == ST_ISSUE && m_ready && !timeout_hit) begin
                to_cnt <= to_cnt + CNT_W'(1);
            end
            // Read data is only meaningful on the cycle the master returns to idle.
            if (state == ST_BUSY && m_ready) begin
                rsp_rw   <= m_rw;
                rsp_data <= m_rw ? m_data_out : '0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a behavioural I2C master model and
// queue-based monitors for issues, responses and timeout pulses.
module tb_i2c_cmd_sequencer;

    localparam int DEPTH       = 4;
    localparam int ACC_TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic [6:0] m_addr;
    logic [7:0] m_data_in;
    logic       m_rw;
    logic       m_enable;
    logic       m_ready;
    logic [7:0] m_data_out;
    logic       rsp_valid;
    logic       rsp_rw;
    logic [7:0] rsp_data;
    logic       err_timeout;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // master model configuration, written only by the stimulus thread
    int         drop_delay = 3;
    int         hold_cycles = 20;
    bit         never_drop = 1'b0;
    logic [7:0] read_val = 8'h00;

    // monitor state, written only by the model / monitor processes
    logic [15:0] issued_q[$];
    logic [8:0]  rsp_q[$];
    int          rsp_cyc_q[$];
    int          en_rise_q[$];
    int          err_cyc_q[$];
    int          en_hi = 0;
    int          err_cnt = 0;
    int          stab_err = 0;
    logic        en_prev = 1'b0;

    logic [15:0] exp_q[$];
    int          last_push_cyc = 0;

    i2c_cmd_sequencer #(
        .DEPTH       (DEPTH),
        .ACC_TIMEOUT (ACC_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_rw      (cmd_rw),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .cmd_ready   (cmd_ready),
        .m_addr      (m_addr),
        .m_data_in   (m_data_in),
        .m_rw        (m_rw),
        .m_enable    (m_enable),
        .m_ready     (m_ready),
        .m_data_out  (m_data_out),
        .rsp_valid   (rsp_valid),
        .rsp_rw      (rsp_rw),
        .rsp_data    (rsp_data),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Master model: accepts an enable, drops ready drop_delay cycles after it rose,
    // holds it low hold_cycles cycles, then returns read_val with ready.
    typedef enum logic [1:0] {M_IDLE, M_WAIT, M_BUSY} mstate_t;
    mstate_t     mst;
    int          mcnt;
    logic [15:0] m_latched;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mst        <= M_IDLE;
            mcnt       <= 0;
            m_ready    <= 1'b1;
            m_data_out <= 8'h00;
            m_latched  <= 16'h0000;
        end else begin
            case (mst)
                M_IDLE: if (m_enable) begin
                    issued_q.push_back({m_rw, m_addr, m_data_in});
                    m_latched <= {m_rw, m_addr, m_data_in};
                    mst       <= M_WAIT;
                    mcnt      <= 1;
                end
                M_WAIT: begin
                    if (m_enable && {m_rw, m_addr, m_data_in} != m_latched) stab_err++;
                    if (!m_enable) begin
                        mst <= M_IDLE;
                    end else if (!never_drop && mcnt == drop_delay - 1) begin
                        m_ready <= 1'b0;
                        mst     <= M_BUSY;
                        mcnt    <= 1;
                    end else begin
                        mcnt <= mcnt + 1;
                    end
                end
                M_BUSY: begin
                    if ({m_rw, m_addr, m_data_in} != m_latched) stab_err++;
                    if (mcnt == hold_cycles) begin
                        m_ready    <= 1'b1;
                        m_data_out <= read_val;
                        mst        <= M_IDLE;
                    end else begin
                        mcnt <= mcnt + 1;
                    end
                end
                default: mst <= M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_enable === 1'b1) en_hi++;
        if (m_enable === 1'b1 && !en_prev) en_rise_q.push_back(cyc);
        en_prev = (m_enable === 1'b1);
        if (rsp_valid === 1'b1) begin
            rsp_q.push_back({rsp_rw, rsp_data});
            rsp_cyc_q.push_back(cyc);
        end
        if (err_timeout === 1'b1) begin
            err_cnt++;
            err_cyc_q.push_back(cyc);
        end
    end

    function automatic logic [8:0] exp_rsp(input logic [15:0] c, input logic [7:0] rd);
        return c[15] ? {1'b1, rd} : 9'h000;
    endfunction

    task automatic push_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] data);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = addr;
        cmd_data  = data;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("[TB] FAIL push_wait cmd_ready=%0b required=1 after %0d cycles", cmd_ready, n);
        end else begin
            exp_q.push_back({rw, addr, data});
        end
        @(negedge clk);
        last_push_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input int budget, input string tag);
        int n = 0;
        while (rsp_q.size() < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (rsp_q.size() < target) begin
            errors++;
            $display("[TB] FAIL %s_rsp_wait responses=%0d required=%0d", tag, rsp_q.size(), target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_rw = 1'b0;
        cmd_addr = 7'h00;
        cmd_data = 8'h00;
        #7;
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        checks++;
        if (m_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_enable got=%b want=0", m_enable); end
        checks++;
        if ({m_rw, m_addr, m_data_in} !== 16'h0000) begin
            errors++; $display("[TB] FAIL reset_m_fields got=%h want=0000", {m_rw, m_addr, m_data_in});
        end
        checks++;
        if ({rsp_valid, rsp_rw, rsp_data, err_timeout} !== 11'h000) begin
            errors++; $display("[TB] FAIL reset_rsp got=%h want=000", {rsp_valid, rsp_rw, rsp_data, err_timeout});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, busy, m_enable} !== 3'b100) begin
            errors++; $display("[TB] FAIL post_reset_idle got=%b want=100", {cmd_ready, busy, m_enable});
        end
    endtask

    task automatic test_write();
        int bi = issued_q.size();
        int br = rsp_q.size();
        int be = en_rise_q.size();
        int bh = en_hi;
        drop_delay = 3; hold_cycles = 20; read_val = 8'h5A;
        push_cmd(1'b0, 7'h44, 8'hF6);
        wait_rsp(br + 1, 100, "write");
        repeat (2) @(posedge clk);
        checks++;
        if (issued_q.size() != bi + 1 || issued_q[bi] !== 16'h44F6) begin
            errors++; $display("[TB] FAIL write_issue count=%0d got=%h want=44F6", issued_q.size() - bi, issued_q[bi]);
        end
        checks++;
        if (rsp_q.size() != br + 1 || rsp_q[br] !== 9'h000) begin
            errors++; $display("[TB] FAIL write_rsp got=%h want=000", rsp_q[br]);
        end
        checks++;
        if (en_rise_q.size() != be + 1 || en_hi - bh != 4) begin
            errors++; $display("[TB] FAIL write_enable_train rises=%0d high=%0d want 1 and 4", en_rise_q.size() - be, en_hi - bh);
        end
        checks++;
        if (en_rise_q[be] != last_push_cyc + 1) begin
            errors++; $display("[TB] FAIL write_latency enable_cycle=%0d want=%0d", en_rise_q[be], last_push_cyc + 1);
        end
        checks++;
        if (rsp_cyc_q[br] - en_rise_q[be] != 24) begin
            errors++; $display("[TB] FAIL write_rsp_timing delta=%0d want=24", rsp_cyc_q[br] - en_rise_q[be]);
        end
        checks++;
        if (stab_err != 0) begin errors++; $display("[TB] FAIL write_stability changes=%0d want=0", stab_err); end
    endtask

    task automatic test_read();
        int bi = issued_q.size();
        int br = rsp_q.size();
        int be = en_rise_q.size();
        read_val = 8'hA5;
        push_cmd(1'b1, 7'h50, 8'h33);
        wait_rsp(br + 1, 100, "read");
        checks++;
        if (issued_q[bi][15:8] !== 8'hD0) begin
            errors++; $display("[TB] FAIL read_issue rw_addr=%h want=D0", issued_q[bi][15:8]);
        end
        checks++;
        if (rsp_q[br] !== 9'h1A5) begin errors++; $display("[TB] FAIL read_rsp got=%h want=1A5", rsp_q[br]); end
        checks++;
        if (rsp_cyc_q[br] - en_rise_q[be] != 24) begin
            errors++; $display("[TB] FAIL read_rsp_timing delta=%0d want=24", rsp_cyc_q[br] - en_rise_q[be]);
        end
    endtask

    task automatic test_fifo_full();
        int bi = issued_q.size();
        int br = rsp_q.size();
        int be = en_rise_q.size();
        int bx = exp_q.size();
        int seen_ready = 0;
        hold_cycles = 40; read_val = 8'h3C;
        push_cmd(1'b0, 7'h10, 8'h01);
        push_cmd(1'b1, 7'h11, 8'h00);
        push_cmd(1'b0, 7'h12, 8'h03);
        push_cmd(1'b1, 7'h13, 8'h00);
        push_cmd(1'b0, 7'h14, 8'h05);
        checks++;
        if ({cmd_ready, busy} !== 2'b01) begin
            errors++; $display("[TB] FAIL full_flags ready_busy=%b want=01", {cmd_ready, busy});
        end
        @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 7'h15; cmd_data = 8'h06;
        repeat (5) begin
            @(negedge clk);
            if (cmd_ready) seen_ready++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (seen_ready != 0) begin errors++; $display("[TB] FAIL full_reject ready_cycles=%0d want=0", seen_ready); end
        wait_rsp(br + 5, 500, "full");
        push_cmd(1'b0, 7'h15, 8'h06);
        wait_rsp(br + 6, 100, "repush");
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (issued_q[bi + i] !== exp_q[bx + i]) begin
                errors++; $display("[TB] FAIL full_order[%0d] got=%h want=%h", i, issued_q[bi + i], exp_q[bx + i]);
            end
            checks++;
            if (rsp_q[br + i] !== exp_rsp(exp_q[bx + i], 8'h3C)) begin
                errors++; $display("[TB] FAIL full_rsp[%0d] got=%h want=%h", i, rsp_q[br + i], exp_rsp(exp_q[bx + i], 8'h3C));
            end
        end
        for (int i = 1; i < 5; i++) begin
            checks++;
            if (en_rise_q[be + i] - rsp_cyc_q[br + i - 1] != 2) begin
                errors++; $display("[TB] FAIL b2b_gap[%0d] got=%0d want=2", i, en_rise_q[be + i] - rsp_cyc_q[br + i - 1]);
            end
        end
    endtask

    task automatic test_timeout();
        int bi = issued_q.size();
        int br = rsp_q.size();
        int be = en_rise_q.size();
        int bh = en_hi;
        int bc = err_cnt;
        int n = 0;
        never_drop = 1'b1; hold_cycles = 20;
        push_cmd(1'b0, 7'h22, 8'h77);
        while (err_cnt == bc && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        checks++;
        if (err_cnt - bc != 1) begin errors++; $display("[TB] FAIL timeout_pulses got=%0d want=1", err_cnt - bc); end
        checks++;
        if (err_cyc_q[bc] - en_rise_q[be] != ACC_TIMEOUT) begin
            errors++; $display("[TB] FAIL timeout_delay got=%0d want=%0d", err_cyc_q[bc] - en_rise_q[be], ACC_TIMEOUT);
        end
        checks++;
        if (en_hi - bh != ACC_TIMEOUT) begin
            errors++; $display("[TB] FAIL timeout_enable_len got=%0d want=%0d", en_hi - bh, ACC_TIMEOUT);
        end
        checks++;
        if (rsp_q.size() != br) begin errors++; $display("[TB] FAIL timeout_no_rsp got=%0d want=%0d", rsp_q.size(), br); end
        never_drop = 1'b0; read_val = 8'h99;
        push_cmd(1'b1, 7'h23, 8'h00);
        wait_rsp(br + 1, 100, "after_timeout");
        checks++;
        if (rsp_q[br] !== 9'h199) begin errors++; $display("[TB] FAIL after_timeout_rsp got=%h want=199", rsp_q[br]); end
        checks++;
        if (issued_q[bi + 1][15:8] !== 8'hA3) begin
            errors++; $display("[TB] FAIL after_timeout_issue rw_addr=%h want=A3", issued_q[bi + 1][15:8]);
        end
    endtask

    task automatic test_reset_busy();
        int n = 0;
        int br;
        int be;
        hold_cycles = 30;
        push_cmd(1'b0, 7'h30, 8'h11);
        while (m_ready !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        push_cmd(1'b0, 7'h31, 8'h22);
        br = rsp_q.size();
        be = en_rise_q.size();
        checks++;
        if ({busy, m_ready} !== 2'b10) begin errors++; $display("[TB] FAIL pre_reset busy_ready=%b want=10", {busy, m_ready}); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, busy, m_enable, rsp_valid, err_timeout} !== 5'b10000) begin
            errors++; $display("[TB] FAIL async_reset_flags got=%b want=10000", {cmd_ready, busy, m_enable, rsp_valid, err_timeout});
        end
        checks++;
        if ({m_rw, m_addr, m_data_in, rsp_rw, rsp_data} !== 25'h0) begin
            errors++; $display("[TB] FAIL async_reset_data got=%h want=0", {m_rw, m_addr, m_data_in, rsp_rw, rsp_data});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || rsp_q.size() != br || en_rise_q.size() != be) begin
            errors++; $display("[TB] FAIL reset_abort busy=%b new_rsp=%0d new_issue=%0d want 0,0,0",
                               busy, rsp_q.size() - br, en_rise_q.size() - be);
        end
    endtask

    task automatic test_push_pop_full();
        int bi = issued_q.size();
        int br = rsp_q.size();
        int bx = exp_q.size();
        drop_delay = 3; hold_cycles = 12; read_val = 8'h6B;
        push_cmd(1'b1, 7'h40, 8'h00);
        push_cmd(1'b0, 7'h41, 8'h0B);
        push_cmd(1'b1, 7'h42, 8'h00);
        push_cmd(1'b0, 7'h43, 8'h0D);
        push_cmd(1'b0, 7'h44, 8'h0E);
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("[TB] FAIL pp_full_before got=%b want=0", cmd_ready); end
        push_cmd(1'b1, 7'h45, 8'h00);
        checks++;
        if ({cmd_ready, busy} !== 2'b01) begin
            errors++; $display("[TB] FAIL pp_full_after ready_busy=%b want=01", {cmd_ready, busy});
        end
        wait_rsp(br + 6, 600, "push_pop");
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (issued_q[bi + i] !== exp_q[bx + i]) begin
                errors++; $display("[TB] FAIL pp_order[%0d] got=%h want=%h", i, issued_q[bi + i], exp_q[bx + i]);
            end
            checks++;
            if (rsp_q[br + i] !== exp_rsp(exp_q[bx + i], 8'h6B)) begin
                errors++; $display("[TB] FAIL pp_rsp[%0d] got=%h want=%h", i, rsp_q[br + i], exp_rsp(exp_q[bx + i], 8'h6B));
            end
        end
        repeat (3) @(posedge clk);
        checks++;
        if (issued_q.size() != bi + 6) begin
            errors++; $display("[TB] FAIL pp_issue_count got=%0d want=6", issued_q.size() - bi);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_fifo_full();
        test_timeout();
        test_reset_busy();
        test_push_pop_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not finish within 500000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
